// File: rtl/bht_port_arbiter.sv
// bht_port_arbiter: shares one BHT port between fetch lookups and buffered updates.
// Define BHT_ARB_STARVE_GUARD_EN to let starved updates pre-empt lookups.
module bht_port_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        lk_valid,
    input  logic [15:0]                 lk_pc,
    output logic                        lk_ready,
    output logic                        rsp_valid,
    output logic                        rsp_taken,
    output logic                        rsp_miss,
    input  logic                        up_valid,
    input  logic [15:0]                 up_pc,
    input  logic                        up_taken,
    output logic                        up_ready,
    input  logic                        flush,
    output logic [15:0]                 bht_pc,
    output logic                        bht_inc_dec,
    output logic                        bht_read_only,
    input  logic [1:0]                  bht_count,
    input  logic                        bht_tag_not_added,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] GNT_IDLE   = 2'd0;
    localparam logic [1:0] GNT_LOOKUP = 2'd1;
    localparam logic [1:0] GNT_UPDATE = 2'd2;

    logic [16:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [16:0]   head;
    logic [1:0]    grant;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          force_upd;
    logic          unused_ok;

    assign empty      = (level == '0);
    assign full       = (level == LW'(FIFO_DEPTH));
    assign up_ready   = !full;
    assign push       = up_valid && !full;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_level = level;
    assign unused_ok  = bht_count[0];

    always_comb begin
        if (force_upd && !empty) begin
            grant = GNT_UPDATE;
        end else if (lk_valid) begin
            grant = GNT_LOOKUP;
        end else if (!empty) begin
            grant = GNT_UPDATE;
        end else begin
            grant = GNT_IDLE;
        end
    end

    assign pop = (grant == GNT_UPDATE);

    always_comb begin
        lk_ready      = 1'b0;
        bht_pc        = 16'h0000;
        bht_read_only = 1'b1;
        bht_inc_dec   = 1'b0;
        unique case (grant)
            GNT_LOOKUP: begin
                lk_ready = 1'b1;
                bht_pc   = lk_pc;
            end
            GNT_UPDATE: begin
                bht_pc        = head[16:1];
                bht_inc_dec   = head[0];
                bht_read_only = 1'b0;
            end
            default: begin
                bht_pc = 16'h0000;
            end
        endcase
    end

    // Storage needs no reset; level and pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr] <= {up_pc, up_taken};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_taken <= 1'b0;
            rsp_miss  <= 1'b0;
        end else begin
            rsp_valid <= (grant == GNT_LOOKUP) && !flush;
            if (grant == GNT_LOOKUP) begin
                rsp_taken <= bht_count[1] && !bht_tag_not_added;
                rsp_miss  <= bht_tag_not_added;
            end
        end
    end

`ifdef BHT_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || empty) begin
            starve_nxt = '0;
        end else if (grant == GNT_LOOKUP && starve_cnt != LIMIT) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Raised on the edge the limit is hit so the very next cycle updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            force_upd  <= 1'b0;
        end else if (flush) begin
            starve_cnt <= '0;
            force_upd  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            if (pop) begin
                force_upd <= 1'b0;
            end else if (starve_nxt == LIMIT) begin
                force_upd <= 1'b1;
            end
        end
    end
`else
    assign force_upd = 1'b0;
`endif

endmodule
